// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// A grant lasts for one burst. The burst ends on the owner's last flag, on
// MAX_BURST words, or when the owner drops its request.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        last,
    input  logic [NREQ*DATA_W-1:0] data_flat,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        gnt,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [DATA_W-1:0]      fifo_data,
    output logic [2:0]             owner_id,
    output logic                   busy
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state, state_next;
    logic [NREQ-1:0]   gnt_next;
    logic [2:0]        owner_next;
    logic [2:0]        last_owner, last_owner_next;
    logic [CNT_W-1:0]  count, count_next;

    logic              owner_req;
    logic              owner_last;
    logic [DATA_W-1:0] owner_word;
    logic              wr;
    logic              release_now;
    int unsigned       best_dist;
    int unsigned       win;

    assign busy = (state == BURST);

    // Select the current owner's request, last flag and word.
    always_comb begin
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_id == 3'(i)) begin
                owner_req  = req[i];
                owner_last = last[i];
                owner_word = data_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // The FIFO strobe and the acks follow the owner combinationally. A word is
    // therefore taken only in the cycle in which the FIFO can accept it.
    always_comb begin
        wr         = busy && owner_req && !fifo_full;
        fifo_wr_en = wr;
        fifo_data  = busy ? owner_word : '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            ack[i] = wr && (owner_id == 3'(i));
        end
        release_now = busy && ((wr && (owner_last || count == CNT_W'(MAX_BURST - 1)))
                               || !owner_req);
    end

    // Next-state logic. The round-robin winner is the requester at the smallest
    // rotational distance after last_owner.
    always_comb begin
        state_next      = state;
        gnt_next        = gnt;
        owner_next      = owner_id;
        count_next      = count;
        last_owner_next = last_owner;
        best_dist       = NREQ;
        win             = 0;
        case (state)
            IDLE: begin
                for (int unsigned j = 0; j < NREQ; j++) begin
                    if (req[j] && ((j + NREQ - 1 - 32'(last_owner)) % NREQ) < best_dist) begin
                        best_dist = (j + NREQ - 1 - 32'(last_owner)) % NREQ;
                        win       = j;
                    end
                end
                if (best_dist < NREQ) begin
                    state_next = BURST;
                    owner_next = 3'(win);
                    count_next = '0;
                    for (int unsigned j = 0; j < NREQ; j++) begin
                        gnt_next[j] = (j == win);
                    end
                end
            end
            BURST: begin
                if (wr) begin
                    count_next = count + CNT_W'(1);
                end
                if (release_now) begin
                    state_next      = IDLE;
                    gnt_next        = '0;
                    last_owner_next = owner_id;
                    count_next      = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register. Reset makes requester 0 the first winner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            gnt        <= '0;
            owner_id   <= '0;
            count      <= '0;
            last_owner <= 3'(NREQ - 1);
        end else begin
            state      <= state_next;
            gnt        <= gnt_next;
            owner_id   <= owner_next;
            count      <= count_next;
            last_owner <= last_owner_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a
// randomized run against a behavioural round-robin model.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } word_t;

    logic                   clk;
    logic                   rstn;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        last;
    logic [NREQ*DATA_W-1:0] data_flat;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        gnt;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [DATA_W-1:0]      fifo_data;
    logic [2:0]             owner_id;
    logic                   busy;

    word_t             q [NREQ][$];
    logic [NREQ-1:0]   pause;
    logic [DATA_W-1:0] wr_log [$];
    int                checks;
    int                errors;

    // reference model state
    bit                m_busy;
    int                m_owner, m_words, m_lastown;
    logic [NREQ-1:0]   e_gnt, e_ack;
    logic              e_wr;
    logic [DATA_W-1:0] e_data;

    fifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rstn(rstn), .req(req), .last(last), .data_flat(data_flat),
        .ack(ack), .gnt(gnt), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data(fifo_data), .owner_id(owner_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int i, input logic [DATA_W-1:0] d, input logic l);
        word_t w;
        w.d = d;
        w.l = l;
        q[i].push_back(w);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() > 0) begin
                req[i]                        = ~pause[i];
                last[i]                       = q[i][0].l;
                data_flat[i*DATA_W +: DATA_W] = q[i][0].d;
            end else begin
                req[i]                        = 1'b0;
                last[i]                       = 1'b0;
                data_flat[i*DATA_W +: DATA_W] = '0;
            end
        end
    endtask

    // Called at a falling edge: log the FIFO write, advance to the next cycle,
    // retire the popped words and present the next inputs.
    task automatic next_cycle(input logic [NREQ-1:0] pop);
        if (fifo_wr_en) wr_log.push_back(fifo_data);
        @(posedge clk);
        for (int i = 0; i < NREQ; i++)
            if (pop[i] && q[i].size() > 0) void'(q[i].pop_front());
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) q[i].delete();
        pause     = '0;
        fifo_full = 1'b0;
        drive_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        wr_log.delete();
    endtask

    task automatic test_reset();
        do_reset();
        rstn = 1'b0;
        push(1, 8'h5A, 1'b1);
        drive_inputs();
        @(posedge clk);
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset gnt: got %b want 0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset wr_en: got %b want 0", fifo_wr_en); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset ack: got %b want 0000", ack); end
        checks++; if (owner_id !== 3'd0) begin errors++; $display("FAIL reset owner_id: got %0d want 0", owner_id); end
        checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL reset data: got %h want 00", fifo_data); end
    endtask

    task automatic test_single_burst();
        logic [3:0] eg [5];
        logic       ew [5];
        logic [7:0] ed [5];
        logic [7:0] el [3];
        eg = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
        ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        el = '{8'hA1, 8'hA2, 8'hA3};
        do_reset();
        push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
        drive_inputs();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (gnt !== eg[c]) begin errors++; $display("FAIL single c%0d gnt: got %b want %b", c, gnt, eg[c]); end
            checks++; if (fifo_wr_en !== ew[c]) begin errors++; $display("FAIL single c%0d wr_en: got %b want %b", c, fifo_wr_en, ew[c]); end
            checks++; if (fifo_data !== ed[c]) begin errors++; $display("FAIL single c%0d data: got %h want %h", c, fifo_data, ed[c]); end
            checks++; if (ack !== (ew[c] ? eg[c] : 4'h0)) begin errors++; $display("FAIL single c%0d ack: got %b want %b", c, ack, ew[c] ? eg[c] : 4'h0); end
            checks++; if (busy !== (eg[c] != 4'h0)) begin errors++; $display("FAIL single c%0d busy: got %b want %b", c, busy, eg[c] != 4'h0); end
            next_cycle(ack);
        end
        checks++; if (wr_log.size() != 3 || wr_log[0] !== el[0] || wr_log[1] !== el[1] || wr_log[2] !== el[2]) begin
            errors++; $display("FAIL single log: got %p want %p", wr_log, el); end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg [9];
        logic       ew [9];
        logic [7:0] ed [9];
        eg = '{4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h4, 4'h0};
        ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ed = '{8'h00, 8'hB0, 8'h00, 8'hC0, 8'h00, 8'hB1, 8'h00, 8'hC1, 8'h00};
        do_reset();
        push(0, 8'hB0, 1'b1); push(0, 8'hB1, 1'b1);
        push(2, 8'hC0, 1'b1); push(2, 8'hC1, 1'b1);
        drive_inputs();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++; if (gnt !== eg[c]) begin errors++; $display("FAIL rr c%0d gnt: got %b want %b", c, gnt, eg[c]); end
            checks++; if (fifo_wr_en !== ew[c]) begin errors++; $display("FAIL rr c%0d wr_en: got %b want %b", c, fifo_wr_en, ew[c]); end
            checks++; if (fifo_data !== ed[c]) begin errors++; $display("FAIL rr c%0d data: got %h want %h", c, fifo_data, ed[c]); end
            if (c == 3) begin
                checks++; if (owner_id !== 3'd2) begin errors++; $display("FAIL rr c3 owner_id: got %0d want 2", owner_id); end
            end
            next_cycle(ack);
        end
    endtask

    task automatic test_max_burst();
        logic [3:0] eg [10];
        logic       ew [10];
        logic [7:0] ed [10];
        eg = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
        ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ed = '{8'h00, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'h00, 8'hD4, 8'hD5, 8'h00, 8'h00};
        do_reset();
        for (int k = 0; k < 6; k++) push(1, 8'hD0 + 8'(k), 1'b0);
        drive_inputs();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (gnt !== eg[c]) begin errors++; $display("FAIL maxb c%0d gnt: got %b want %b", c, gnt, eg[c]); end
            checks++; if (fifo_wr_en !== ew[c]) begin errors++; $display("FAIL maxb c%0d wr_en: got %b want %b", c, fifo_wr_en, ew[c]); end
            checks++; if (fifo_data !== ed[c]) begin errors++; $display("FAIL maxb c%0d data: got %h want %h", c, fifo_data, ed[c]); end
            next_cycle(ack);
        end
        checks++; if (wr_log.size() != 6) begin errors++; $display("FAIL maxb log size: got %0d want 6", wr_log.size()); end
    endtask

    task automatic test_full_stall();
        logic [3:0] eg [8];
        logic       ew [8];
        logic       ef [8];
        logic [7:0] ed [8];
        logic [7:0] el [4];
        eg = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
        ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ef = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ed = '{8'h00, 8'hE0, 8'hE1, 8'hE1, 8'hE1, 8'hE2, 8'hE3, 8'h00};
        el = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
        do_reset();
        push(3, 8'hE0, 1'b0); push(3, 8'hE1, 1'b0); push(3, 8'hE2, 1'b0); push(3, 8'hE3, 1'b1);
        drive_inputs();
        for (int c = 0; c < 8; c++) begin
            fifo_full = ef[c];
            @(negedge clk);
            checks++; if (gnt !== eg[c]) begin errors++; $display("FAIL full c%0d gnt: got %b want %b", c, gnt, eg[c]); end
            checks++; if (fifo_wr_en !== ew[c]) begin errors++; $display("FAIL full c%0d wr_en: got %b want %b", c, fifo_wr_en, ew[c]); end
            checks++; if (fifo_data !== ed[c]) begin errors++; $display("FAIL full c%0d data: got %h want %h", c, fifo_data, ed[c]); end
            checks++; if (ack !== (ew[c] ? eg[c] : 4'h0)) begin errors++; $display("FAIL full c%0d ack: got %b want %b", c, ack, ew[c] ? eg[c] : 4'h0); end
            next_cycle(ack);
        end
        checks++; if (wr_log.size() != 4 || wr_log[0] !== el[0] || wr_log[1] !== el[1] || wr_log[2] !== el[2] || wr_log[3] !== el[3]) begin
            errors++; $display("FAIL full log: got %p want %p", wr_log, el); end
    endtask

    task automatic test_req_drop();
        logic [3:0] eg [5];
        logic       ew [5];
        logic       ep [5];
        logic [7:0] ed [5];
        eg = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2};
        ew = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ep = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ed = '{8'h00, 8'hF0, 8'hF1, 8'h00, 8'h70};
        do_reset();
        push(0, 8'hF0, 1'b0); push(0, 8'hF1, 1'b0); push(1, 8'h70, 1'b1);
        drive_inputs();
        for (int c = 0; c < 5; c++) begin
            pause[0] = ep[c];
            drive_inputs();
            @(negedge clk);
            checks++; if (gnt !== eg[c]) begin errors++; $display("FAIL drop c%0d gnt: got %b want %b", c, gnt, eg[c]); end
            checks++; if (fifo_wr_en !== ew[c]) begin errors++; $display("FAIL drop c%0d wr_en: got %b want %b", c, fifo_wr_en, ew[c]); end
            checks++; if (fifo_data !== ed[c]) begin errors++; $display("FAIL drop c%0d data: got %h want %h", c, fifo_data, ed[c]); end
            next_cycle(ack);
        end
    endtask

    task automatic test_reset_midburst();
        logic [3:0] eg [5];
        logic       ew [5];
        logic [7:0] ed [5];
        eg = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h2};
        ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ed = '{8'h00, 8'h90, 8'h00, 8'h91, 8'h92};
        do_reset();
        push(1, 8'h90, 1'b1); push(1, 8'h91, 1'b0); push(1, 8'h92, 1'b0); push(1, 8'h93, 1'b0);
        drive_inputs();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (gnt !== eg[c]) begin errors++; $display("FAIL rstmid c%0d gnt: got %b want %b", c, gnt, eg[c]); end
            checks++; if (fifo_wr_en !== ew[c]) begin errors++; $display("FAIL rstmid c%0d wr_en: got %b want %b", c, fifo_wr_en, ew[c]); end
            checks++; if (fifo_data !== ed[c]) begin errors++; $display("FAIL rstmid c%0d data: got %h want %h", c, fifo_data, ed[c]); end
            if (c < 4) next_cycle(ack);
        end
        push(0, 8'h30, 1'b1); push(2, 8'h50, 1'b1);
        rstn = 1'b0;
        #1;
        checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL rstmid gnt in reset: got %b want 0000", gnt); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid wr_en in reset: got %b want 0", fifo_wr_en); end
        checks++; if (busy !== 1'b0 || ack !== 4'h0) begin errors++; $display("FAIL rstmid busy/ack in reset: got %b/%b want 0/0000", busy, ack); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive_inputs();
        @(negedge clk);
        checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL rstmid after release gnt: got %b want 0000", gnt); end
        next_cycle(ack);
        @(negedge clk);
        checks++; if (gnt !== 4'h1 || fifo_data !== 8'h30) begin errors++; $display("FAIL rstmid first grant: got %b/%h want 0001/30", gnt, fifo_data); end
        checks++; if (wr_log.size() != 2) begin errors++; $display("FAIL rstmid log size: got %0d want 2", wr_log.size()); end
    endtask

    // Reference model: expected outputs for the current cycle.
    task automatic model_eval();
        e_wr   = m_busy && req[m_owner] && !fifo_full;
        e_gnt  = m_busy ? NREQ'(1 << m_owner) : '0;
        e_ack  = e_wr ? NREQ'(1 << m_owner) : '0;
        e_data = m_busy ? data_flat[m_owner*DATA_W +: DATA_W] : '0;
    endtask

    // Reference model: effect of the coming clock edge.
    task automatic model_step();
        if (!m_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (!m_busy && req[(m_lastown + k) % NREQ]) begin
                    m_busy  = 1;
                    m_owner = (m_lastown + k) % NREQ;
                    m_words = 0;
                end
            end
        end else begin
            if (e_wr) m_words++;
            if (!req[m_owner] || (e_wr && (last[m_owner] || m_words == MAX_BURST))) begin
                m_busy    = 0;
                m_lastown = m_owner;
            end
        end
    endtask

    task automatic test_random();
        bit drained;
        drained = 0;
        do_reset();
        m_busy = 0; m_owner = 0; m_words = 0; m_lastown = NREQ - 1;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            @(negedge clk);
            model_eval();
            checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rand cyc%0d gnt: got %b want %b", cyc, gnt, e_gnt); end
            checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand cyc%0d busy: got %b want %b", cyc, busy, m_busy); end
            checks++; if (fifo_wr_en !== e_wr) begin errors++; $display("FAIL rand cyc%0d wr_en: got %b want %b", cyc, fifo_wr_en, e_wr); end
            checks++; if (ack !== e_ack) begin errors++; $display("FAIL rand cyc%0d ack: got %b want %b", cyc, ack, e_ack); end
            checks++; if (fifo_data !== e_data) begin errors++; $display("FAIL rand cyc%0d data: got %h want %h", cyc, fifo_data, e_data); end
            if (m_busy) begin
                checks++; if (owner_id !== 3'(m_owner)) begin errors++; $display("FAIL rand cyc%0d owner_id: got %0d want %0d", cyc, owner_id, m_owner); end
            end
            if (cyc >= 700 && !m_busy && req == '0 && q[0].size() == 0 && q[1].size() == 0
                && q[2].size() == 0 && q[3].size() == 0) begin
                drained = 1;
                break;
            end
            model_step();
            next_cycle(e_ack);
            if (cyc < 700) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (q[i].size() < 5 && $urandom_range(0, 3) == 0)
                        push(i, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0));
                    pause[i] = ($urandom_range(0, 9) == 0);
                end
                fifo_full = ($urandom_range(0, 3) == 0);
            end else begin
                pause     = '0;
                fifo_full = 1'b0;
            end
            drive_inputs();
        end
        checks++; if (!drained) begin errors++; $display("FAIL rand drain: got pending words want none within cycle budget"); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        pause     = '0;
        fifo_full = 1'b0;
        req       = '0;
        last      = '0;
        data_flat = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst();
        test_full_stall();
        test_req_drop();
        test_reset_midburst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one 8-bit FIFO write port (wr_en/data_in/full) between NREQ producers. A granted producer owns the port for a burst that ends on its last flag, on MAX_BURST words, or when it drops its request. Sits directly in front of the 4-deep fifo write side. Drives the FIFO strobe combinationally from the current owner so that no word is lost or duplicated under full back-pressure.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, word width, matches fifo data_in
MAX_BURST, 4, max words per grant before forced release (1..255)

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request, held while it has words
last  input  NREQ  per-requester: current word is final of burst
data_flat  input  NREQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]
ack  output  NREQ  combinational, one-hot: requester's word written this cycle
gnt  output  NREQ  registered one-hot grant, all-zero when idle
fifo_full  input  1  fifo full flag
fifo_wr_en  output  1  fifo write strobe, combinational
fifo_data  output  DATA_W  fifo data_in, combinational mux of owner word
owner_id  output  3  index of current owner, valid when busy=1
busy  output  1  1 in BURST state

Behaviour:
- Reset (async, rstn low): state=IDLE, gnt=0, busy=0, owner_id=0, word count=0, last_owner=NREQ-1 (requester 0 wins first). Comb outputs follow: fifo_wr_en=0, ack=0.
- Reset asserted mid-burst aborts the burst immediately. No further writes occur. The FIFO is not reset by this block.
- States: IDLE, BURST.
- IDLE: fifo_wr_en=0, ack=0, fifo_data=0.
  - If any req bit set at the clock edge, the winner is the first set bit searching last_owner+1, last_owner+2, … mod NREQ.
  - On that edge: gnt<=onehot(winner), owner_id<=winner, count<=0, state<=BURST.
  - Latency: req sampled at edge k gives gnt at edge k; first possible write in the cycle after edge k.
- BURST:
  - fifo_data = owner word.
  - fifo_wr_en = req[owner] & ~fifo_full.
  - ack[owner] = fifo_wr_en; all other ack bits 0.
- On each write: count<=count+1.
- Release to IDLE (gnt<=0, last_owner<=owner, count<=0) at the edge where any of these holds:
  - a write occurs with last[owner]=1;
  - a write occurs with count==MAX_BURST-1;
  - req[owner]=0 (no write that cycle).
- One idle bubble cycle always separates bursts. A new winner is chosen in IDLE, never in BURST.
- fifo_full=1 in BURST: no write, count holds, grant held, no release unless req[owner] drops.
- last[owner] is ignored in cycles with no write (stalled by full).
- Requests from non-owners are ignored during BURST and considered at the next IDLE.
- Count width is ceil(log2(MAX_BURST+1)). Pointer arithmetic is modulo NREQ.
- Protocol requirement on requesters: data_flat and last stay stable while req=1 and ack=0.

Test Plan:
- Req0 alone, words A1,A2,A3, last on A3, fifo empty → gnt=0001 one cycle after req; fifo_wr_en high 3 consecutive cycles writing A1,A2,A3; gnt=0 and busy=0 the cycle after A3.
- Req0 and req2 asserted together from reset, 1 word each with last → requester 0 writes first, one bubble cycle, then requester 2. A following req0+req2 pair grants 0 first again (last_owner=2 wraps to 0).
- Req1 burst of 6 words, no last, MAX_BURST=4 → 4 writes, then forced release. If req1 is the only requester, it is re-granted after the bubble and writes the remaining 2 words.
- Fill the fifo: fifo_full=1 during req3's 2nd word → fifo_wr_en=0 and ack=0 while full; gnt held; word 2 written exactly once after full drops; total 4 FIFO entries with no duplicate.
- Owner req drops mid-burst after 1 word → release at that edge; the waiting requester is granted next.
- rstn pulsed low during the 2nd word of a burst → gnt=0, fifo_wr_en=0 immediately. After release, the first grant goes to requester 0.
